// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and helpers for the MEM-stage data-memory responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE_LANES = 4;

    // Misaligned byte addresses and anything beyond the word array are rejected, never aliased.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte write enables and registered read data
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage request channel
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;
    logic [BYTE_LANES-1:0] be_q;
    logic                  load_ok;
    logic                  commit;
    logic [31:0]           mem_rdata;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign commit    = (state == WAIT) && (cnt == '0) && !rst;
    // The RAM read register has no reset, so the response data is gated until a good load commits.
    assign rsp_rdata = load_ok ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            load_ok   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= access_err(req_addr, ADDR_W);
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        load_ok   <= !we_q && !err_q;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        load_ok   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (commit && !err_q),
        .be    (be_q & {BYTE_LANES{we_q}}),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench over four responder instances with different latencies
module tb_dmem_responder;

    localparam int N = 4;
    localparam int LAT [N] = '{2, 4, 1, 3};

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_be    [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];
    logic        busy      [N];
    logic        prev_valid [N];

    exp_t        sb_q [$];
    logic [31:0] model [int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W  (10),
            .LATENCY (LAT[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        #1;
        for (int d = 0; d < N; d++) begin
            if (rsp_valid[d] === 1'b1 && prev_valid[d] !== 1'b1) begin
                if (sb_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check($sformatf("rsp_latency%0d", d), 32'(cyc - sb_q[0].acc), 32'(LAT[d]));
            end
            if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("rsp_extra", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_inst", 32'(d), 32'(e.inst));
                    check($sformatf("rsp_rdata%0d", d), rsp_rdata[d], e.rdata);
                    check($sformatf("rsp_err%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
                end
            end
            prev_valid[d] = rsp_valid[d];
        end
    end

    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit track, output int acc);
        exp_t        e;
        int          n;
        int          key;
        logic [31:0] word;
        @(negedge clk);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc    = cyc + 1;
        e.inst = d;
        e.acc  = acc;
        e.err  = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
        e.rdata = 32'd0;
        key    = d * 1024 + int'(addr[11:2]);
        if (track) begin
            if (!e.err && we) begin
                word = model.exists(key) ? model[key] : 32'd0;
                for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                model[key] = word;
            end else if (!e.err) begin
                e.rdata = model.exists(key) ? model[key] : 32'hBAD0BAD0;
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic req_off(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy[d] !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int n;
        for (int d = 0; d < N; d++) begin
            rst[d]        = 1'b1;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            req_be[d]     = 4'h0;
            rsp_ready[d]  = 1'b1;
            prev_valid[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("rst_rsp_err",   {31'd0, rsp_err[d]},   32'd0);
            check("rst_rsp_rdata", rsp_rdata[d],          32'd0);
            check("rst_busy",      {31'd0, busy[d]},      32'd0);
            check("rst_req_ready", {31'd0, req_ready[d]}, 32'd0);
        end
        for (int d = 0; d < N; d++) rst[d] = 1'b0;

        // basic, byte-enable and error cases on the LATENCY=2 instance
        issue(0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1, acc);
        issue(0, 1'b0, 32'h10,   32'h0,        4'h0, 1, acc);
        issue(0, 1'b1, 32'h10,   32'h000000AA, 4'h1, 1, acc);
        issue(0, 1'b0, 32'h10,   32'h0,        4'h0, 1, acc);
        issue(0, 1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 1, acc);
        issue(0, 1'b0, 32'h10,   32'h0,        4'h0, 1, acc);
        issue(0, 1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 1, acc);
        issue(0, 1'b0, 32'h13,   32'h0,        4'h0, 1, acc);
        issue(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1, acc);
        issue(0, 1'b0, 32'h0,    32'h0,        4'h0, 1, acc);
        issue(0, 1'b1, 32'hFFC,  32'h0BADC0DE, 4'hF, 1, acc);
        issue(0, 1'b0, 32'hFFC,  32'h0,        4'h0, 1, acc);
        issue(0, 1'b0, 32'h1,    32'h0,        4'h0, 1, acc);
        req_off(0);
        wait_drain(0);
        check("model_word10", model[32'h10 >> 2], 32'hDEADBEAA);

        // backpressure with a competing request held on the channel
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, acc);
        @(negedge clk);
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h0;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0],          32'hDEADBEAA);
            check("bp_rsp_err",   {31'd0, rsp_err[0]},   32'd0);
            check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        wait_drain(0);
        repeat (6) @(negedge clk);
        check("bp_no_accept", {31'd0, busy[0]}, 32'd0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, acc);
        req_off(0);
        wait_drain(0);

        // reset while a store waits out its latency
        issue(1, 1'b1, 32'h20, 32'h11111111, 4'hF, 1, acc);
        req_off(1);
        wait_drain(1);
        issue(1, 1'b1, 32'h20, 32'h00000055, 4'hF, 0, acc);
        @(negedge clk);
        @(negedge clk);
        check("wait_busy", {31'd0, busy[1]}, 32'd1);
        rst[1]       = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("midrst_busy",      {31'd0, busy[1]},      32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready[1]}, 32'd0);
        rst[1] = 1'b0;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 1, acc);
        req_off(1);
        wait_drain(1);

        // back-to-back streaming with req_valid and rsp_ready held high
        for (int d = 2; d < N; d++) begin
            prev = -1;
            for (int i = 0; i < 16; i++) begin
                issue(d, i < 8, 32'h100 + 32'((i % 8) * 4), $urandom, 4'hF, 1, acc);
                if (i > 0) check($sformatf("stream_gap%0d", d), 32'(acc - prev), 32'(LAT[d] + 2));
                prev = acc;
            end
            req_off(d);
            wait_drain(d);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's MEM stage. It is the target side of the load/store request channel that MEMSeg drives.
- Accepts one word-oriented load or store request at a time over a valid/ready handshake.
- Models a fixed, parameterised access latency, then returns the result on a valid/ready response channel.
- Flags misaligned and out-of-range accesses instead of aliasing them.

Parameters:
- ADDR_W, 10, word-address bits; memory depth = 2^ADDR_W words of 32 bits.
- LATENCY, 2, cycles from the request-accept edge to rsp_valid asserting; legal values >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i selects byte lane [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  access was misaligned or out of range.
- busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at any time.
- Reset:
  - Applies on any clk edge while rst = 1: state <= IDLE, counter <= 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 0.
  - req_ready = 0 while rst is high.
  - Memory contents are not reset.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid && req_ready, latch we, addr, wdata and be.
  - Compute err = (addr[1:0] != 0) || (addr[31:ADDR_W+2] != 0).
  - Load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready = 0; req_valid is ignored.
  - On each edge with counter != 0, decrement the counter.
  - On the edge with counter == 0, commit the access and go to RESP:
    - Store, no error: for each i with be[i] = 1, mem[addr[ADDR_W+1:2]] byte i <= wdata byte i. Result data = 0.
    - Load, no error: result data = mem word.
    - Error: memory is untouched; result data = 0 and err = 1.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err hold stable until the handshake.
  - req_ready = 0.
  - On an edge with rsp_ready = 1, go to IDLE; rsp_valid drops after that edge.
- Timing:
  - Request accepted at edge k puts rsp_valid high in the cycle after edge k+LATENCY.
  - With rsp_ready tied high, the earliest next accept is edge k+LATENCY+2, so throughput is one transaction per LATENCY+2 cycles.
  - LATENCY = 1: WAIT lasts exactly one cycle.
- Counter width is $clog2(LATENCY+1); there is no wrap-around because the counter only counts down to 0.
- Reset mid-operation:
  - Reset in WAIT before the commit edge: the store is discarded and memory is unchanged.
  - Reset in RESP: the response is dropped.
- Store with be = 0000: legal, memory unchanged, acknowledged with err = 0.
- A store is always acknowledged with rsp_valid; the requester must consume the response.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/WAIT/RESP);
  - the byte-lane count constant (4);
  - the error-check function (alignment and range).
- One sub-module, dmem_array:
  - single-port synchronous RAM, 2^ADDR_W x 32, with per-byte write enables;
  - read data registered on the commit edge;
  - no reset.

Test Plan:
- Basic store/load (LATENCY = 2): store 0xDEADBEEF to 0x10 with be = 1111 → rsp_valid rises 2 cycles after accept, rdata = 0, err = 0. Then load 0x10 → rdata = 0xDEADBEEF.
- Byte enables: store 0x000000AA to 0x10 with be = 0001 → a subsequent load of 0x10 returns 0xDEADBEAA. A store with be = 0000 leaves it unchanged.
- Errors:
  - load 0x13 → err = 1, rdata = 0;
  - with ADDR_W = 10, store 0x12345678 to 0x1000 → err = 1, and a load of 0x0 still returns its prior value (no aliasing).
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_valid, rdata and err stay stable, req_ready = 0, and a concurrent req_valid is not accepted.
- Reset mid-WAIT: store 0x55 to 0x20 (LATENCY = 4), assert rst 2 cycles after accept → busy = 0, rsp_valid = 0, and a later load of 0x20 returns the old value.
- Streaming: req_valid and rsp_ready held high with 8 loads at LATENCY = 1 and LATENCY = 3 → accepts every 3 and every 5 cycles respectively, with responses in order.
